// File: rtl/pulse_measure_if.sv
// Bundle of the enable/signal inputs and the result handshake of pulse_measure.
// The result uses a valid/ack handshake. oValid rises with a new result and holds oWidth/oOverflow stable.
// The transfer completes on the first rising edge where oValid=1 and iAck=1. iAck has no effect while oValid=0.
interface pulse_measure_if #(
    parameter int MAX_COUNT = 255
);
    localparam int CNT_BITS = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);

    logic                iEn;
    logic                iSig;
    logic                iAck;
    logic [CNT_BITS-1:0] oWidth;
    logic                oValid;
    logic                oOverflow;
    logic                oBusy;
    logic                oMissed;
    logic [1:0]          oDbgState;

    modport master (
        output iEn, iSig, iAck,
        input  oWidth, oValid, oOverflow, oBusy, oMissed, oDbgState
    );

    modport slave (
        input  iEn, iSig, iAck,
        output oWidth, oValid, oOverflow, oBusy, oMissed, oDbgState
    );
endinterface

// File: rtl/pulse_measure.sv
// Measures the high time of iSig in clock cycles and holds each result until it is acknowledged.
// Widths above MAX_COUNT saturate and raise an overflow flag.
module pulse_measure #(
    parameter int MAX_COUNT = 255
) (
    input  logic             iClk,
    input  logic             iRst,
    pulse_measure_if.slave   bus
);
    localparam int CNT_BITS = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
    localparam logic [CNT_BITS-1:0] MAX_VAL = CNT_BITS'(MAX_COUNT);
    localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_ovf_flag;
    logic                r_prev;
    logic [CNT_BITS-1:0] r_width;
    logic                r_valid;
    logic                r_overflow;
    logic                r_busy;
    logic                r_missed;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
            r_prev     <= 1'b0;
            r_width    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            r_prev   <= bus.iSig;
            r_missed <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Arming only on a low sample keeps a pulse already in progress from being measured.
                    if (bus.iEn && !bus.iSig) begin
                        r_state <= ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!bus.iEn) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (bus.iSig) begin
                        r_state    <= MEASURE;
                        r_cnt      <= ONE;
                        r_ovf_flag <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!bus.iEn) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_cnt      <= '0;
                        r_ovf_flag <= 1'b0;
                    end else if (bus.iSig) begin
                        if (r_cnt == MAX_VAL) begin
                            r_ovf_flag <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end else begin
                        r_state    <= HOLD;
                        r_width    <= r_cnt;
                        r_overflow <= r_ovf_flag;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cnt      <= '0;
                        r_ovf_flag <= 1'b0;
                    end
                end
                HOLD: begin
                    // Rising edges seen while the result waits are flagged, never measured.
                    if (bus.iSig && !r_prev) begin
                        r_missed <= 1'b1;
                    end
                    if (bus.iAck) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oWidth    = r_width;
    assign bus.oValid    = r_valid;
    assign bus.oOverflow = r_overflow;
    assign bus.oBusy     = r_busy;
    assign bus.oMissed   = r_missed;
    assign bus.oDbgState = r_state;
endmodule

// File: tb/tb_pulse_measure.sv
// Drives two pulse_measure instances (MAX_COUNT 255 and 7) with the same stimulus.
// Each result is checked against pulse-level expectations: width = min(N, MAX), overflow = N > MAX.
module tb_pulse_measure;
    localparam int MAX_A = 255;
    localparam int MAX_B = 7;

    logic clk;
    logic rst;

    pulse_measure_if #(.MAX_COUNT(MAX_A)) b_a ();
    pulse_measure_if #(.MAX_COUNT(MAX_B)) b_b ();

    pulse_measure #(.MAX_COUNT(MAX_A)) dut_a (.iClk(clk), .iRst(rst), .bus(b_a));
    pulse_measure #(.MAX_COUNT(MAX_B)) dut_b (.iClk(clk), .iRst(rst), .bus(b_b));

    assign b_b.iEn  = b_a.iEn;
    assign b_b.iSig = b_a.iSig;
    assign b_b.iAck = b_a.iAck;

    // Observed output vectors: {valid, overflow, busy, missed, width}.
    logic [11:0] obs_a;
    logic [6:0]  obs_b;
    assign obs_a = {b_a.oValid, b_a.oOverflow, b_a.oBusy, b_a.oMissed, b_a.oWidth};
    assign obs_b = {b_b.oValid, b_b.oOverflow, b_b.oBusy, b_b.oMissed, b_b.oWidth};

    logic [11:0] exp_a;
    logic [6:0]  exp_b;
    logic [7:0]  last_w_a;
    logic [2:0]  last_w_b;
    logic        last_o_a;
    logic        last_o_b;
    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one pulse: low for low_n cycles, high for high_n cycles, then low.
    // A negative ack_wait leaves the result held without acknowledging it.
    task automatic run_pulse(input int low_n, input int high_n, input int ack_wait);
        b_a.iSig = 1'b0;
        repeat (low_n) tick();
        exp_a = {1'b0, last_o_a, 1'b1, 1'b0, last_w_a};
        exp_b = {1'b0, last_o_b, 1'b1, 1'b0, last_w_b};
        n_cmp += 2;
        if (obs_a !== exp_a) begin n_err++; $display("FAIL armed_a t=%0t got=%h want=%h", $time, obs_a, exp_a); end
        if (obs_b !== exp_b) begin n_err++; $display("FAIL armed_b t=%0t got=%h want=%h", $time, obs_b, exp_b); end
        b_a.iSig = 1'b1;
        for (int i = 0; i < high_n; i++) begin
            tick();
            n_cmp += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL measure_a t=%0t got=%h want=%h", $time, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL measure_b t=%0t got=%h want=%h", $time, obs_b, exp_b); end
        end
        b_a.iSig = 1'b0;
        tick();
        last_w_a = (high_n > MAX_A) ? 8'(MAX_A) : 8'(high_n);
        last_o_a = (high_n > MAX_A);
        last_w_b = (high_n > MAX_B) ? 3'(MAX_B) : 3'(high_n);
        last_o_b = (high_n > MAX_B);
        exp_a = {1'b1, last_o_a, 1'b0, 1'b0, last_w_a};
        exp_b = {1'b1, last_o_b, 1'b0, 1'b0, last_w_b};
        n_cmp += 2;
        if (obs_a !== exp_a) begin n_err++; $display("FAIL result_a n=%0d got=%h want=%h", high_n, obs_a, exp_a); end
        if (obs_b !== exp_b) begin n_err++; $display("FAIL result_b n=%0d got=%h want=%h", high_n, obs_b, exp_b); end
        if (ack_wait >= 0) begin
            for (int i = 0; i < ack_wait; i++) begin
                tick();
                n_cmp += 2;
                if (obs_a !== exp_a) begin n_err++; $display("FAIL hold_a t=%0t got=%h want=%h", $time, obs_a, exp_a); end
                if (obs_b !== exp_b) begin n_err++; $display("FAIL hold_b t=%0t got=%h want=%h", $time, obs_b, exp_b); end
            end
            b_a.iAck = 1'b1;
            tick();
            b_a.iAck = 1'b0;
            exp_a = {1'b0, last_o_a, 1'b0, 1'b0, last_w_a};
            exp_b = {1'b0, last_o_b, 1'b0, 1'b0, last_w_b};
            n_cmp += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL ack_a t=%0t got=%h want=%h", $time, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL ack_b t=%0t got=%h want=%h", $time, obs_b, exp_b); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b_a.iEn = 1'b1;
        b_a.iSig = 1'b0;
        b_a.iAck = 1'b1;
        repeat (3) tick();
        last_w_a = '0; last_o_a = 1'b0; last_w_b = '0; last_o_b = 1'b0;
        n_cmp += 2;
        if (obs_a !== 12'h000) begin n_err++; $display("FAIL reset_a got=%h want=000", obs_a); end
        if (obs_b !== 7'h00) begin n_err++; $display("FAIL reset_b got=%h want=00", obs_b); end
        b_a.iAck = 1'b0;
        b_a.iEn = 1'b0;
        rst = 1'b0;
        tick();
        b_a.iEn = 1'b1;
    endtask

    task automatic test_basic();
        run_pulse(2, 10, 0);
    endtask

    task automatic test_saturate();
        run_pulse(1, 12, 1);
        run_pulse(1, MAX_B, 0);
        run_pulse(1, MAX_B + 1, 2);
        run_pulse(1, 1, 0);
        run_pulse(1, MAX_A, 0);
        run_pulse(3, MAX_A + 1, 0);
    endtask

    task automatic test_pre_high();
        b_a.iEn = 1'b0;
        b_a.iSig = 1'b1;
        tick();
        b_a.iEn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_a = {1'b0, last_o_a, 1'b0, 1'b0, last_w_a};
            exp_b = {1'b0, last_o_b, 1'b0, 1'b0, last_w_b};
            n_cmp += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL prehigh_a got=%h want=%h", obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL prehigh_b got=%h want=%h", obs_b, exp_b); end
        end
        run_pulse(1, 3, 0);
    endtask

    // Result held for 20 cycles while a 4-cycle pulse passes and iEn briefly drops.
    task automatic test_hold_missed();
        logic prev_sig;
        logic sig;
        logic exp_m;
        int missed_seen;
        missed_seen = 0;
        run_pulse(2, 6, -1);
        prev_sig = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sig = (i >= 5 && i < 9);
            b_a.iSig = sig;
            b_a.iEn = !(i >= 10 && i < 15);
            tick();
            exp_m = sig && !prev_sig;
            prev_sig = sig;
            if (b_a.oMissed === 1'b1) missed_seen++;
            exp_a = {1'b1, last_o_a, 1'b0, exp_m, last_w_a};
            exp_b = {1'b1, last_o_b, 1'b0, exp_m, last_w_b};
            n_cmp += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL held_a i=%0d got=%h want=%h", i, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL held_b i=%0d got=%h want=%h", i, obs_b, exp_b); end
        end
        n_cmp++;
        if (missed_seen !== 1) begin n_err++; $display("FAIL missed_count got=%0d want=1", missed_seen); end
        b_a.iEn = 1'b1;
        b_a.iAck = 1'b1;
        tick();
        b_a.iAck = 1'b0;
        n_cmp++;
        if (b_a.oValid !== 1'b0) begin n_err++; $display("FAIL hold_ack got=%b want=0", b_a.oValid); end
        run_pulse(1, 4, 0);
    endtask

    task automatic test_ack_coincide();
        run_pulse(1, 5, -1);
        b_a.iSig = 1'b1;
        tick();
        exp_a = {1'b1, last_o_a, 1'b0, 1'b1, last_w_a};
        n_cmp++;
        if (obs_a !== exp_a) begin n_err++; $display("FAIL coincide_miss got=%h want=%h", obs_a, exp_a); end
        b_a.iAck = 1'b1;
        tick();
        b_a.iAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_a = {1'b0, last_o_a, 1'b0, 1'b0, last_w_a};
            n_cmp++;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL coincide_skip got=%h want=%h", obs_a, exp_a); end
        end
        run_pulse(1, 2, 0);
    endtask

    task automatic test_reset_mid();
        b_a.iSig = 1'b0;
        tick();
        b_a.iSig = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_w_a = '0; last_o_a = 1'b0; last_w_b = '0; last_o_b = 1'b0;
        n_cmp += 2;
        if (obs_a !== 12'h000) begin n_err++; $display("FAIL rstmid_a got=%h want=000", obs_a); end
        if (obs_b !== 7'h00) begin n_err++; $display("FAIL rstmid_b got=%h want=00", obs_b); end
        run_pulse(1, 2, 0);
    endtask

    task automatic test_en_drop();
        b_a.iSig = 1'b0;
        tick();
        b_a.iSig = 1'b1;
        repeat (4) tick();
        b_a.iEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            b_a.iSig = 1'b0;
            exp_a = {1'b0, last_o_a, 1'b0, 1'b0, last_w_a};
            exp_b = {1'b0, last_o_b, 1'b0, 1'b0, last_w_b};
            n_cmp += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL endrop_a i=%0d got=%h want=%h", i, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL endrop_b i=%0d got=%h want=%h", i, obs_b, exp_b); end
        end
        b_a.iEn = 1'b1;
        run_pulse(1, 1, 0);
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) n = $urandom_range(MAX_A - 3, MAX_A + 3);
            else n = $urandom_range(1, 20);
            run_pulse($urandom_range(1, 4), n, $urandom_range(0, 3));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        b_a.iEn = 1'b0;
        b_a.iSig = 1'b0;
        b_a.iAck = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_pre_high();
        test_hold_missed();
        test_ack_coincide();
        test_reset_mid();
        test_en_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pulse_measure.md
PULSE_MEASURE -- requirements
Module: pulse_measure

Interface
REQ-001 Parameter: MAX_COUNT, default 255; largest pulse width in clock cycles that is reported exactly. MAX_COUNT SHALL be >= 1.
REQ-002 Parameter: CNT_BITS, derived, not overridable; = ceiling(log2(MAX_COUNT+1)), minimum 1.
REQ-003 iClk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 iRst  input  1  synchronous, active-high reset.
REQ-005 iEn  input  1  measurement enable.
REQ-006 iSig  input  1  signal under measurement; synchronous to iClk, sampled every cycle.
REQ-007 iAck  input  1  consumer acknowledge of the held result.
REQ-008 oWidth  output  CNT_BITS  measured high time in cycles.
REQ-009 oValid  output  1  result held and awaiting iAck.
REQ-010 oOverflow  output  1  pulse width exceeded MAX_COUNT; qualified by oValid.
REQ-011 oBusy  output  1  high in ARMED or MEASURE.
REQ-012 oMissed  output  1  single-cycle pulse when a rising edge is lost during HOLD.

Function
REQ-013 State machine: IDLE, ARMED, MEASURE, HOLD. All outputs SHALL be registered.
REQ-014 IDLE -> ARMED when iEn=1 and iSig=0. A pulse already high at enable SHALL NOT be measured.
REQ-015 ARMED -> MEASURE when iSig=1. The counter SHALL load 1 on that same edge.
REQ-016 MEASURE with iSig=1: counter increments by 1 and saturates at MAX_COUNT; the next increment attempt at MAX_COUNT sets the internal overflow flag.
REQ-017 MEASURE with iSig=0 -> HOLD: oWidth <= counter, oOverflow <= flag, oValid <= 1, all on the same edge.
REQ-018 Resulting width rule: a pulse sampled high for exactly N cycles SHALL give oWidth=N, oOverflow=0 for 1<=N<=MAX_COUNT.
REQ-019 Width rule above MAX_COUNT: N>MAX_COUNT SHALL give oWidth=MAX_COUNT, oOverflow=1.
REQ-020 Latency: oValid rises on the edge at which iSig is first sampled low after the pulse.
REQ-021 HOLD: oWidth, oOverflow and oValid SHALL stay stable until iAck=1 is sampled. iAck SHALL be ignored outside HOLD.
REQ-022 HOLD with iAck=1 -> IDLE; oValid <= 0 on the same edge. oWidth and oOverflow keep their last values.
REQ-023 A rising edge on iSig (iSig=1 while the previous sample was 0) while in HOLD SHALL pulse oMissed for one cycle. That pulse SHALL NOT be measured.
REQ-024 iEn=0 in ARMED or MEASURE -> IDLE on the next edge: counter cleared, no result, oValid stays 0.
REQ-025 iEn=0 in HOLD SHALL NOT affect the held result or the handshake.
REQ-026 Ack and a new pulse coincide: HOLD -> IDLE -> ARMED requires iSig=0. A pulse already high at that time is skipped, per REQ-014.
REQ-027 Counter arithmetic SHALL be CNT_BITS wide, unsigned, with no wrap-around.

Reset
REQ-028 iRst=1 sampled at a clock edge SHALL force state IDLE and set counter, overflow flag, previous-sample register, oWidth, oValid, oOverflow, oBusy and oMissed all to 0. This applies from any state, including mid-measurement and HOLD.
REQ-029 iRst SHALL take priority over iEn and iAck. The first state transition SHALL occur on the first edge with iRst=0.

Verification
REQ-030 MAX_COUNT=255, iEn=1, iSig low 2 cycles, high 10 cycles, then low -> oValid=1 on the first low-sample edge, oWidth=10, oOverflow=0, oBusy=0; iAck one cycle -> oValid=0 next edge.
REQ-031 MAX_COUNT=7, pulse high 12 cycles -> oWidth=7, oOverflow=1. Also MAX_COUNT=7, pulse high 7 cycles -> oWidth=7, oOverflow=0.
REQ-032 iSig already high when iEn rises, stays high 5 cycles, low 1 cycle, then high 3 cycles -> only the second pulse reported: oWidth=3.
REQ-033 Result held, iAck=0 for 20 cycles, 4-cycle pulse arrives -> oValid, oWidth unchanged throughout; oMissed=1 for exactly one cycle; no new result.
REQ-034 Reset mid-measurement: iRst=1 for one cycle at count 6 -> all outputs 0 next edge; later 2-cycle pulse -> oWidth=2.
REQ-035 iEn dropped at count 4 -> IDLE, oValid stays 0; 1-cycle pulse after re-enable -> oWidth=1.
